// File: rtl/gr_heep_obi_slave_cut.sv
`default_nettype none
// ============================================================================
// Module   : obi_pkg / gr_heep_obi_slave_cut
// Brief    : Registered OBI cut for one crossbar slave port. A small request
//            FIFO breaks req->gnt, a response register breaks rvalid/rdata,
//            the outstanding count is capped and spurious peripheral
//            responses raise a sticky error.
// Revision : 1.0 - initial release
// ============================================================================

package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module gr_heep_obi_slave_cut #(
  parameter int REQ_DEPTH       = 2,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CntWidth       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  obi_pkg::obi_req_t    xbar_req_i,
  output obi_pkg::obi_resp_t   xbar_resp_o,
  output obi_pkg::obi_req_t    periph_req_o,
  input  obi_pkg::obi_resp_t   periph_resp_i,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int PtrWidth  = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int FillWidth = $clog2(REQ_DEPTH + 1);

  // Request payload as stored in the FIFO (the req bit itself is implied).
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } entry_t;

  entry_t                fifo_mem [REQ_DEPTH];
  logic [PtrWidth-1:0]   wr_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic [FillWidth-1:0]  fill;

  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic [CntWidth-1:0]   cnt;
  logic                  err;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  gnt;
  logic                  accept;
  logic                  pop;
  logic [CntWidth-1:0]   inflight;
  logic                  spurious;
  logic                  capture;
  entry_t                head;

  assign fifo_full  = (fill == FillWidth'(REQ_DEPTH));
  assign fifo_empty = (fill == '0);

  // Grant is a function of registered state only; rst_i masks it so that
  // nothing is granted while the block is being held in reset.
  assign gnt    = !rst_i && !fifo_full && (cnt < CntWidth'(MAX_OUTSTANDING));
  assign accept = xbar_req_i.req && gnt;
  assign pop    = !fifo_empty && periph_resp_i.gnt;

  // Transactions handed to the peripheral whose response has not come back.
  assign inflight = cnt - CntWidth'(fill) - CntWidth'(resp_valid);
  assign spurious = periph_resp_i.rvalid && (inflight == '0);
  assign capture  = periph_resp_i.rvalid && !spurious;

  assign head = fifo_mem[rd_ptr];

  // Downstream request: FIFO head, payload forced to zero when idle.
  always_comb begin
    periph_req_o       = '0;
    periph_req_o.req   = !fifo_empty;
    if (!fifo_empty) begin
      periph_req_o.we    = head.we;
      periph_req_o.be    = head.be;
      periph_req_o.addr  = head.addr;
      periph_req_o.wdata = head.wdata;
    end
  end

  // Upstream response: grant plus the registered response beat.
  always_comb begin
    xbar_resp_o        = '0;
    xbar_resp_o.gnt    = gnt;
    xbar_resp_o.rvalid = resp_valid;
    xbar_resp_o.rdata  = resp_rdata;
  end

  assign outstanding_o = cnt;
  assign busy_o        = (cnt != '0);
  assign err_o         = err;

  // FIFO storage write; contents need no reset since the output is gated.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= '{we:    xbar_req_i.we,
                            be:    xbar_req_i.be,
                            addr:  xbar_req_i.addr,
                            wdata: xbar_req_i.wdata};
    end
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= (wr_ptr == PtrWidth'(REQ_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PtrWidth'(REQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        fill <= fill + 1'b1;
      end else if (!accept && pop) begin
        fill <= fill - 1'b1;
      end
    end
  end

  // Response register: one upstream beat per legitimate peripheral beat;
  // rdata keeps its last value between beats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= capture;
      if (capture) begin
        resp_rdata <= periph_resp_i.rdata;
      end
    end
  end

  // Outstanding counter: up on accept, down on the upstream beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (accept && !resp_valid) begin
      cnt <= cnt + 1'b1;
    end else if (!accept && resp_valid) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Sticky error on a peripheral beat with nothing in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (spurious) begin
      err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gr_heep_obi_slave_cut.sv
`default_nettype none
// ============================================================================
// Module   : tb_gr_heep_obi_slave_cut
// Brief    : Self-checking bench for gr_heep_obi_slave_cut: directed scenarios
//            plus random traffic compared against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gr_heep_obi_slave_cut;

  localparam int REQ_DEPTH       = 2;
  localparam int MAX_OUTSTANDING = 4;
  localparam int CntWidth        = $clog2(MAX_OUTSTANDING + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  obi_pkg::obi_req_t   xreq;
  obi_pkg::obi_resp_t  xresp;
  obi_pkg::obi_req_t   preq;
  obi_pkg::obi_resp_t  presp;
  logic [CntWidth-1:0] outstanding;
  logic                busy;
  logic                err;

  gr_heep_obi_slave_cut #(
    .REQ_DEPTH       (REQ_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .xbar_req_i    (xreq),
    .xbar_resp_o   (xresp),
    .periph_req_o  (preq),
    .periph_resp_i (presp),
    .outstanding_o (outstanding),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending requests, outstanding total, transactions
  // handed to the peripheral, and the response beat due upstream.
  logic [68:0] m_q[$];
  logic [31:0] m_popped[$];
  int          m_cnt;
  int          m_issued;
  bit          m_rv;
  logic [31:0] m_rdata;
  bit          m_err;

  bit obs_gnt;
  bit obs_rv;
  bit accepted;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_cnt    = 0;
    m_issued = 0;
    m_rv     = 0;
    m_rdata  = '0;
    m_err    = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model,
  // then advance the model across the rising edge.
  task automatic step(input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic pgnt, input logic prv, input logic [31:0] prdata);
    bit exp_gnt;
    bit acc;
    bit pop;
    bit nrv;
    @(negedge clk);
    xreq.req   = req;
    xreq.we    = we;
    xreq.be    = be;
    xreq.addr  = addr;
    xreq.wdata = wdata;
    presp.gnt    = pgnt;
    presp.rvalid = prv;
    presp.rdata  = prdata;
    #1;
    exp_gnt = (m_q.size() < REQ_DEPTH) && (m_cnt < MAX_OUTSTANDING);
    check_value("xbar_gnt", 32'(xresp.gnt), 32'(exp_gnt));
    check_value("periph_req", 32'(preq.req), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_value("periph_addr", preq.addr, m_q[0][63:32]);
      check_value("periph_wdata", preq.wdata, m_q[0][31:0]);
      check_value("periph_we_be", 32'({preq.we, preq.be}), 32'(m_q[0][68:64]));
    end
    check_value("xbar_rvalid", 32'(xresp.rvalid), 32'(m_rv));
    check_value("xbar_rdata", xresp.rdata, m_rdata);
    check_value("outstanding", 32'(outstanding), 32'(m_cnt));
    check_value("busy", 32'(busy), 32'(m_cnt != 0));
    check_value("err", 32'(err), 32'(m_err));
    obs_gnt = xresp.gnt;
    obs_rv  = xresp.rvalid;
    @(posedge clk);
    acc = req && exp_gnt;
    pop = (m_q.size() != 0) && pgnt;
    nrv = 0;
    if (prv) begin
      if (m_issued > 0) begin
        nrv = 1;
        m_issued--;
      end else begin
        m_err = 1;
      end
    end
    m_cnt = m_cnt + (acc ? 1 : 0) - (m_rv ? 1 : 0);
    if (pop) begin
      m_popped.push_back(m_q[0][31:0]);
      void'(m_q.pop_front());
      m_issued++;
    end
    if (acc) m_q.push_back({we, be, addr, wdata});
    m_rv = nrv;
    if (nrv) m_rdata = prdata;
    accepted = acc;
  endtask

  task automatic idle(input logic pgnt);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, pgnt, 1'b0, 32'h0);
  endtask

  // Apply reset for two edges with a pending upstream request.
  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    xreq  = '0;
    xreq.req = 1'b1;
    presp = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_value("rst_gnt", 32'(xresp.gnt), 32'h0);
    check_value("rst_preq", 32'(preq.req), 32'h0);
    check_value("rst_paddr", preq.addr, 32'h0);
    check_value("rst_outstanding", 32'(outstanding), 32'h0);
    check_value("rst_busy", 32'(busy), 32'h0);
    check_value("rst_err", 32'(err), 32'h0);
    check_value("rst_rvalid", 32'(xresp.rvalid), 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    xreq = '0;
    #1;
    check_value("post_rst_gnt", 32'(xresp.gnt), 32'h1);
    model_clear();
  endtask

  // Answer everything still in flight, bounded in cycles.
  task automatic drain();
    for (int i = 0; i < 64 && (m_cnt != 0 || m_q.size() != 0); i++) begin
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'(m_issued > 0), $urandom);
    end
    check_value("drain_done", 32'(m_cnt), 32'h0);
  endtask

  initial begin
    int grants;
    xreq  = '0;
    presp = '0;
    model_clear();

    do_reset();

    // Single read with a fixed latency profile.
    step(1'b1, 1'b0, 4'hF, 32'h2000_0010, 32'h0, 1'b0, 1'b0, 32'h0);
    check_value("rd_accept", 32'(accepted), 32'h1);
    #1;
    check_value("rd_preq_c1", 32'(preq.req), 32'h1);
    check_value("rd_paddr_c1", preq.addr, 32'h2000_0010);
    idle(1'b1);
    idle(1'b0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    #1;
    check_value("rd_rvalid_c4", 32'(xresp.rvalid), 32'h1);
    check_value("rd_rdata_c4", xresp.rdata, 32'hDEAD_BEEF);
    check_value("rd_cnt_c4", 32'(outstanding), 32'h1);
    idle(1'b0);
    #1;
    check_value("rd_cnt_c5", 32'(outstanding), 32'h0);
    check_value("rd_rvalid_c5", 32'(xresp.rvalid), 32'h0);
    check_value("rd_rdata_hold", xresp.rdata, 32'hDEAD_BEEF);

    // Back-to-back writes against a stalled peripheral.
    m_popped.delete();
    step(1'b1, 1'b1, 4'h3, 32'h2000_0100, 32'h11, 1'b0, 1'b0, 32'h0);
    check_value("wr1_accept", 32'(accepted), 32'h1);
    step(1'b1, 1'b1, 4'h3, 32'h2000_0100, 32'h22, 1'b0, 1'b0, 32'h0);
    check_value("wr2_accept", 32'(accepted), 32'h1);
    step(1'b1, 1'b1, 4'h3, 32'h2000_0100, 32'h33, 1'b0, 1'b0, 32'h0);
    check_value("wr3_gnt", 32'(obs_gnt), 32'h0);
    accepted = 0;
    for (int i = 0; i < 6 && !accepted; i++) begin
      step(1'b1, 1'b1, 4'h3, 32'h2000_0100, 32'h33, 1'b1, 1'b0, 32'h0);
    end
    check_value("wr3_accept", 32'(accepted), 32'h1);
    for (int i = 0; i < 8 && m_q.size() != 0; i++) idle(1'b1);
    check_value("wr_pop_count", 32'(m_popped.size()), 32'd3);
    if (m_popped.size() == 3) begin
      check_value("wr_order0", m_popped[0], 32'h11);
      check_value("wr_order1", m_popped[1], 32'h22);
      check_value("wr_order2", m_popped[2], 32'h33);
    end
    drain();

    // Outstanding cap with a silent peripheral, then simultaneous +/-.
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 4'hF, 32'h2000_0200 + 32'(i), 32'h0, 1'b1, 1'b0, 32'h0);
      if (obs_gnt) grants++;
    end
    check_value("cap_grants", 32'(grants), 32'd4);
    check_value("cap_cnt", 32'(outstanding), 32'd4);
    step(1'b1, 1'b0, 4'hF, 32'h2000_0300, 32'h0, 1'b1, 1'b1, 32'hA5A5_0001);
    check_value("cap_gnt_x0", 32'(obs_gnt), 32'h0);
    step(1'b1, 1'b0, 4'hF, 32'h2000_0300, 32'h0, 1'b1, 1'b1, 32'hA5A5_0002);
    check_value("cap_gnt_x1", 32'(obs_gnt), 32'h0);
    check_value("cap_rv_x1", 32'(obs_rv), 32'h1);
    step(1'b1, 1'b0, 4'hF, 32'h2000_0300, 32'h0, 1'b1, 1'b0, 32'h0);
    check_value("cap_gnt_x2", 32'(obs_gnt), 32'h1);
    check_value("cap_rv_x2", 32'(obs_rv), 32'h1);
    #1;
    check_value("simul_cnt", 32'(outstanding), 32'd3);
    do_reset();

    // Spurious peripheral response.
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0);
    #1;
    check_value("spur_err", 32'(err), 32'h1);
    check_value("spur_rvalid", 32'(xresp.rvalid), 32'h0);
    check_value("spur_cnt", 32'(outstanding), 32'h0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check_value("spur_sticky", 32'(err), 32'h1);
    do_reset();
    check_value("spur_cleared", 32'(err), 32'h0);

    // Random traffic: busy and quiet response phases.
    for (int i = 0; i < 600; i++) begin
      int rv_div;
      rv_div = (i < 300) ? 2 : 8;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
           $urandom, $urandom, 1'($urandom_range(0, 3) != 0),
           1'((m_issued > 0) && ($urandom_range(0, rv_div - 1) == 0)), $urandom);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
